// File: rtl/regbank_if.sv
// Register bank port bundle: one write/step command port, two read ports
// and the registered zero flag from the last increment/decrement.
//
// Handshake: there is no valid/ready pair. The write port takes one command
// per clock. wop=00 is the idle encoding, and any other wop is executed
// unconditionally at the next rising edge. Read ports are pure
// combinational lookups that are valid whenever their address is stable.
interface regbank_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic [1:0]         wop;
    logic [AW-1:0]      wa;
    logic [WIDTH/8-1:0] wbe;
    logic [WIDTH-1:0]   din;
    logic [AW-1:0]      ra;
    logic [AW-1:0]      rb;
    logic [WIDTH-1:0]   da;
    logic [WIDTH-1:0]   db;
    logic               wz;

    modport master (
        output wop, wa, wbe, din, ra, rb,
        input  da, db, wz
    );

    modport slave (
        input  wop, wa, wbe, din, ra, rb,
        output da, db, wz
    );
endinterface

// File: rtl/regbank.sv
// Bank of NREGS registers with one write port and two combinational read
// ports. The write port does byte-lane loads and in-place increment or
// decrement, so PC/SP-style counters can step without the ALU. With
// BYPASS=1 the read ports forward the value a pending write will store.
module regbank #(
    parameter int              WIDTH     = 32,
    parameter int              NREGS     = 16,
    parameter int              AW        = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit              BYPASS    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    regbank_if.slave   bus
);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic             wa_ok;
    logic             fwd;
    logic             wz_q;

    // Address decode: the target and read values come from explicit compares,
    // so addresses at or beyond NREGS match nothing and read as zero.
    always_comb begin
        cur   = '0;
        rd_a  = '0;
        rd_b  = '0;
        wa_ok = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.wa == AW'(i)) begin
                cur   = regs[i];
                wa_ok = 1'b1;
            end
            if (bus.ra == AW'(i)) rd_a = regs[i];
            if (bus.rb == AW'(i)) rd_b = regs[i];
        end
    end

    // Value the target register takes at the next edge for the current wop.
    always_comb begin
        nxt = cur;
        case (bus.wop)
            2'b01: begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.wbe[b]) nxt[8*b +: 8] = bus.din[8*b +: 8];
                end
            end
            2'b10:   nxt = cur + WIDTH'(1);
            2'b11:   nxt = cur - WIDTH'(1);
            default: nxt = cur;
        endcase
    end

    // Read ports: stored value, or the pending write value when forwarding is built in.
    always_comb begin
        fwd    = !reset && (bus.wop != 2'b00) && wa_ok;
        bus.da = rd_a;
        bus.db = rd_b;
        if (BYPASS && fwd && (bus.ra == bus.wa)) bus.da = nxt;
        if (BYPASS && fwd && (bus.rb == bus.wa)) bus.db = nxt;
    end

    // Register storage: reset wins; otherwise only the addressed register updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
        end else if (bus.wop != 2'b00) begin
            for (int i = 0; i < NREGS; i++) begin
                if (bus.wa == AW'(i)) regs[i] <= nxt;
            end
        end
    end

    // Zero flag: updated only by inc/dec. A discarded step to an invalid address reports zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            wz_q <= 1'b0;
        end else if (bus.wop[1]) begin
            wz_q <= wa_ok ? (nxt == '0) : 1'b1;
        end
    end

    assign bus.wz = wz_q;
endmodule

// File: tb/tb_regbank.sv
// Bench for regbank. Two instances: u0 (NREGS=12, RESET_VAL=5, no bypass)
// and u1 (NREGS=16, RESET_VAL=0, bypass). Inputs change 1ns after the
// rising edge and outputs are sampled before the next edge.
`timescale 1ns/1ps
module tb_regbank;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic [31:0] m0 [12];
    logic [31:0] m1 [16];
    logic        mwz0;
    logic        mwz1;

    regbank_if #(.WIDTH(32), .AW(4)) bus0 ();
    regbank_if #(.WIDTH(32), .AW(4)) bus1 ();

    regbank #(.WIDTH(32), .NREGS(12), .AW(4), .RESET_VAL(32'h5), .BYPASS(1'b0))
        u0 (.clk(clk), .reset(rst0), .bus(bus0));
    regbank #(.WIDTH(32), .NREGS(16), .AW(4), .RESET_VAL(32'h0), .BYPASS(1'b1))
        u1 (.clk(clk), .reset(rst1), .bus(bus1));

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Reference behaviour of one write-port operation on a register value.
    function automatic logic [31:0] model_next(input logic [31:0] r, input logic [1:0] op,
                                               input logic [3:0] be, input logic [31:0] d);
        logic [31:0] v;
        v = r;
        if (op == 2'b01) begin
            if (be[0]) v[7:0]   = d[7:0];
            if (be[1]) v[15:8]  = d[15:8];
            if (be[2]) v[23:16] = d[23:16];
            if (be[3]) v[31:24] = d[31:24];
        end else if (op == 2'b10) begin
            v = r + 32'd1;
        end else if (op == 2'b11) begin
            v = r - 32'd1;
        end
        return v;
    endfunction

    // Driver for u0: apply one command at the next edge and update the model.
    task automatic wr0(input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] be, input logic [31:0] d);
        logic [31:0] v;
        bus0.wop = op; bus0.wa = a; bus0.wbe = be; bus0.din = d;
        @(posedge clk);
        if (rst0) begin
            for (int i = 0; i < 12; i++) m0[i] = 32'h5;
            mwz0 = 1'b0;
        end else if (op != 2'b00) begin
            if (a < 4'd12) begin
                v = model_next(m0[a], op, be, d);
                m0[a] = v;
                if (op[1]) mwz0 = (v == 32'h0);
            end else if (op[1]) begin
                mwz0 = 1'b1;
            end
        end
        #1;
        bus0.wop = 2'b00;
    endtask

    // Driver for u1.
    task automatic wr1(input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] be, input logic [31:0] d);
        logic [31:0] v;
        bus1.wop = op; bus1.wa = a; bus1.wbe = be; bus1.din = d;
        @(posedge clk);
        if (rst1) begin
            for (int i = 0; i < 16; i++) m1[i] = 32'h0;
            mwz1 = 1'b0;
        end else if (op != 2'b00) begin
            v = model_next(m1[a], op, be, d);
            m1[a] = v;
            if (op[1]) mwz1 = (v == 32'h0);
        end
        #1;
        bus1.wop = 2'b00;
    endtask

    task automatic test_reset;
        rst0 = 1'b1; rst1 = 1'b1;
        bus1.wop = 2'b01; bus1.wa = 4'd3; bus1.wbe = 4'hF; bus1.din = 32'hFFFF_FFFF;
        wr0(2'b01, 4'd3, 4'hF, 32'hFFFF_FFFF);
        bus1.wop = 2'b00;
        for (int i = 0; i < 16; i++) m1[i] = 32'h0;
        mwz1 = 1'b0;
        rst0 = 1'b0; rst1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus0.ra = 4'(i); bus0.rb = 4'(i);
            exp_q.push_back(32'h5);
            exp_q.push_back(32'h5);
            #0.5;
            exp_v = exp_q.pop_front(); n_vec++;
            if (bus0.da !== exp_v) begin n_err++; $display("FAIL reset_da[%0d]: got %h expected %h", i, bus0.da, exp_v); end
            exp_v = exp_q.pop_front(); n_vec++;
            if (bus0.db !== exp_v) begin n_err++; $display("FAIL reset_db[%0d]: got %h expected %h", i, bus0.db, exp_v); end
        end
        n_vec++;
        if (bus0.wz !== 1'b0) begin n_err++; $display("FAIL reset_wz: got %b expected 0", bus0.wz); end
        bus1.ra = 4'd3; #0.5;
        n_vec++;
        if (bus1.da !== 32'h0) begin n_err++; $display("FAIL reset_u1: got %h expected 0", bus1.da); end
    endtask

    task automatic test_byte_lane;
        wr0(2'b01, 4'd2, 4'hF, 32'h1122_3344);
        wr0(2'b01, 4'd2, 4'b0101, 32'hAABB_CCDD);
        exp_q.push_back(32'h11BB_33DD);
        bus0.ra = 4'd2; #0.5;
        exp_v = exp_q.pop_front(); n_vec++;
        if (bus0.da !== exp_v) begin n_err++; $display("FAIL byte_lane: got %h expected %h", bus0.da, exp_v); end
        wr0(2'b01, 4'd2, 4'b0000, 32'h9999_9999);
        exp_q.push_back(32'h11BB_33DD);
        bus0.rb = 4'd2; #0.5;
        exp_v = exp_q.pop_front(); n_vec++;
        if (bus0.db !== exp_v) begin n_err++; $display("FAIL byte_lane_none: got %h expected %h", bus0.db, exp_v); end
        n_vec++;
        if (bus0.wz !== 1'b0) begin n_err++; $display("FAIL load_wz: got %b expected 0", bus0.wz); end
    endtask

    task automatic test_wrap;
        logic [1:0]  ops [3];
        logic [31:0] vals [3];
        logic        zs [3];
        ops[0] = 2'b10; vals[0] = 32'h0000_0000; zs[0] = 1'b1;
        ops[1] = 2'b11; vals[1] = 32'hFFFF_FFFF; zs[1] = 1'b0;
        ops[2] = 2'b00; vals[2] = 32'hFFFF_FFFF; zs[2] = 1'b0;
        wr0(2'b01, 4'd1, 4'hF, 32'hFFFF_FFFF);
        bus0.ra = 4'd1;
        for (int k = 0; k < 3; k++) begin
            wr0(ops[k], 4'd1, 4'h0, 32'h0);
            exp_q.push_back(vals[k]);
            exp_q.push_back({31'h0, zs[k]});
            #0.5;
            exp_v = exp_q.pop_front(); n_vec++;
            if (bus0.da !== exp_v) begin n_err++; $display("FAIL wrap_val[%0d]: got %h expected %h", k, bus0.da, exp_v); end
            exp_v = exp_q.pop_front(); n_vec++;
            if (bus0.wz !== exp_v[0]) begin n_err++; $display("FAIL wrap_wz[%0d]: got %b expected %b", k, bus0.wz, exp_v[0]); end
        end
    endtask

    task automatic test_forward;
        // Bypass instance: result visible before the edge.
        wr1(2'b01, 4'd4, 4'hF, 32'h7);
        bus1.wop = 2'b10; bus1.wa = 4'd4; bus1.ra = 4'd4; bus1.rb = 4'd4;
        #1;
        n_vec++;
        if (bus1.da !== 32'h8) begin n_err++; $display("FAIL fwd_da_pre: got %h expected 8", bus1.da); end
        n_vec++;
        if (bus1.db !== 32'h8) begin n_err++; $display("FAIL fwd_db_pre: got %h expected 8", bus1.db); end
        @(posedge clk); m1[4] = 32'h8; mwz1 = 1'b0; #1; bus1.wop = 2'b00;
        #0.5;
        n_vec++;
        if (bus1.da !== 32'h8) begin n_err++; $display("FAIL fwd_da_post: got %h expected 8", bus1.da); end
        // Non-bypass instance: old value before the edge, new value after.
        wr0(2'b01, 4'd4, 4'hF, 32'h7);
        bus0.wop = 2'b10; bus0.wa = 4'd4; bus0.ra = 4'd4; bus0.rb = 4'd4;
        #1;
        n_vec++;
        if (bus0.da !== 32'h7) begin n_err++; $display("FAIL nofwd_da_pre: got %h expected 7", bus0.da); end
        n_vec++;
        if (bus0.db !== 32'h7) begin n_err++; $display("FAIL nofwd_db_pre: got %h expected 7", bus0.db); end
        @(posedge clk); m0[4] = 32'h8; mwz0 = 1'b0; #1; bus0.wop = 2'b00;
        #0.5;
        n_vec++;
        if (bus0.da !== 32'h8) begin n_err++; $display("FAIL nofwd_da_post: got %h expected 8", bus0.da); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] snap [12];
        wr0(2'b10, 4'd0, 4'h0, 32'h0);
        for (int i = 0; i < 12; i++) snap[i] = m0[i];
        wr0(2'b01, 4'd13, 4'hF, 32'hDEAD_BEEF);
        wr0(2'b10, 4'd15, 4'hF, 32'h0);
        n_vec++;
        if (bus0.wz !== 1'b1) begin n_err++; $display("FAIL oor_wz: got %b expected 1", bus0.wz); end
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(snap[i]);
            bus0.ra = 4'(i); #0.5;
            exp_v = exp_q.pop_front(); n_vec++;
            if (bus0.da !== exp_v) begin n_err++; $display("FAIL oor_keep[%0d]: got %h expected %h", i, bus0.da, exp_v); end
        end
        bus0.ra = 4'd13; bus0.rb = 4'd15; #0.5;
        n_vec++;
        if (bus0.da !== 32'h0) begin n_err++; $display("FAIL oor_read_a: got %h expected 0", bus0.da); end
        n_vec++;
        if (bus0.db !== 32'h0) begin n_err++; $display("FAIL oor_read_b: got %h expected 0", bus0.db); end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 5; k++) begin
            rst0 = (k == 2);
            wr0(2'b10, 4'd0, 4'h0, 32'h0);
        end
        rst0 = 1'b0;
        bus0.ra = 4'd0; bus0.rb = 4'd2; #0.5;
        n_vec++;
        if (bus0.da !== 32'h7) begin n_err++; $display("FAIL rst_mid_r0: got %h expected 7", bus0.da); end
        n_vec++;
        if (bus0.db !== 32'h5) begin n_err++; $display("FAIL rst_mid_r2: got %h expected 5", bus0.db); end
        n_vec++;
        if (bus0.wz !== 1'b0) begin n_err++; $display("FAIL rst_mid_wz: got %b expected 0", bus0.wz); end
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [3:0]  a, r, s, be;
        logic [31:0] d;
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = 4'($urandom_range(0, 15));
            r  = ($urandom_range(0, 1) == 1) ? a : 4'($urandom_range(0, 15));
            s  = 4'($urandom_range(0, 15));
            be = 4'($urandom_range(0, 15));
            d  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            bus1.wop = op; bus1.wa = a; bus1.wbe = be; bus1.din = d;
            bus1.ra = r; bus1.rb = s;
            exp_q.push_back((op != 2'b00 && r == a) ? model_next(m1[a], op, be, d) : m1[r]);
            exp_q.push_back((op != 2'b00 && s == a) ? model_next(m1[a], op, be, d) : m1[s]);
            #1;
            exp_v = exp_q.pop_front(); n_vec++;
            if (bus1.da !== exp_v) begin n_err++; $display("FAIL rand_da[%0d]: got %h expected %h", n, bus1.da, exp_v); end
            exp_v = exp_q.pop_front(); n_vec++;
            if (bus1.db !== exp_v) begin n_err++; $display("FAIL rand_db[%0d]: got %h expected %h", n, bus1.db, exp_v); end
            wr1(op, a, be, d);
            n_vec++;
            if (bus1.wz !== mwz1) begin n_err++; $display("FAIL rand_wz[%0d]: got %b expected %b", n, bus1.wz, mwz1); end
        end
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.wop = 2'b00; bus0.wa = '0; bus0.wbe = '0; bus0.din = '0; bus0.ra = '0; bus0.rb = '0;
        bus1.wop = 2'b00; bus1.wa = '0; bus1.wbe = '0; bus1.din = '0; bus1.ra = '0; bus1.rb = '0;
        mwz0 = 1'b0; mwz1 = 1'b0;
        @(posedge clk); #1;
        test_reset;
        test_byte_lane;
        test_wrap;
        test_forward;
        test_out_of_range;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regbank.md
Name: regbank

Overview:
- Parametrised successor to the single clock-enabled register: a bank of NREGS registers with one write port and two combinational read ports.
- The write port supports byte-lane loads plus in-place increment and decrement.
- Intended for CPU architectural state, including general registers and PC/SP-style counters that step without going through the ALU.
- Optional write-to-read forwarding supports single-cycle pipelines.

Parameters:
WIDTH, 32, register width in bits; must be a multiple of 8 and at least 8
NREGS, 16, number of registers; minimum 2; need not be a power of two
AW, 4, address width; must satisfy 2**AW >= NREGS
RESET_VAL, 0, value loaded into every register on reset (WIDTH bits)
BYPASS, 0, 1 = read ports forward the pending write value; 0 = read ports show stored contents only

Ports:
clk  input  1  clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
wop  input  2  write operation: 00 hold, 01 load, 10 increment, 11 decrement
wa  input  AW  write/step target address
wbe  input  WIDTH/8  byte-lane enables for load; bit i covers din[8i+7:8i]
din  input  WIDTH  load data
ra  input  AW  read port A address
rb  input  AW  read port B address
da  output  WIDTH  read port A data
db  output  WIDTH  read port B data
wz  output  1  registered flag: 1 when the last executed inc/dec produced zero

Behaviour:
- Clock and reset:
  - One clock (clk); reset is synchronous and active-high (reset), sampled only on the rising edge of clk.
  - reset=1 at an edge: every register <= RESET_VAL and wz <= 0, regardless of wop, wa, wbe or din. Reset overrides any concurrent operation.
  - Reset asserted mid-sequence (e.g. during an inc run): the next edge yields RESET_VAL in all registers; the increment is lost.
  - Before the first reset edge, contents are undefined; the bench must reset first.
- Write port, applied at the edge when reset=0:
  - wop=00: no register changes; wz holds.
  - wop=01: for each i with wbe[i]=1, R[wa] byte i <= din byte i. Lanes with wbe[i]=0 keep their value. wbe=0 makes the load a no-op. wz holds.
  - wop=10: R[wa] <= R[wa]+1, modulo 2**WIDTH; all-ones wraps to 0. wbe is ignored. wz <= (result==0).
  - wop=11: R[wa] <= R[wa]-1, modulo 2**WIDTH; 0 wraps to all-ones. wbe is ignored. wz <= (result==0).
  - wa >= NREGS: the operation is discarded and no register changes. wz still updates on inc/dec with a computed result of 0, i.e. the discarded op reports zero.
- Read ports:
  - Fully combinational, zero latency; A and B are independent and may address the same register.
  - Address >= NREGS reads 0.
  - BYPASS=0: output is the stored register value. A write becomes visible the cycle after its edge.
  - BYPASS=1: if reset=0, wop!=00, the write address is valid and the read address equals wa, the output is the value R[wa] will take at the next edge (merged load bytes, or inc/dec result). Otherwise the output is the stored value. No bypass while reset=1.
- Timing: write-to-read latency is 1 edge with BYPASS=0 and 0 cycles with BYPASS=1. wz is valid the cycle after the inc/dec edge.
- Arithmetic: unsigned WIDTH-bit; no carry/borrow output.
- Structure:
  - Storage is registers, no RAM inference.
  - No combinational path from any input to wz.
  - Combinational paths wa/wop/wbe/din -> da/db exist only when BYPASS=1.

Test Plan:
- Reset, RESET_VAL=0x0000_0005: after one edge with reset=1 and wop=01, wa=3, din=0xFFFFFFFF, wbe=4'hF, every register reads 0x5 on both ports and wz=0.
- Byte-lane load: R2=0x11223344; wop=01, wa=2, wbe=4'b0101, din=0xAABBCCDD -> R2=0x11BB33DD. A following wbe=0 load leaves 0x11BB33DD.
- Wrap:
  - R1=0xFFFFFFFF, wop=10 -> R1=0x00000000, wz=1.
  - wop=11 -> R1=0xFFFFFFFF, wz=0.
  - wop=00 -> wz stays 0.
- Forwarding:
  - BYPASS=1, R4=7, wop=10, wa=4, ra=rb=4 -> da=db=8 in the same cycle, before the edge.
  - BYPASS=0, same stimulus -> da=7 before the edge, 8 after.
- Out of range, NREGS=12, AW=4:
  - wop=01, wa=13 -> no register changes.
  - ra=13 -> da=0.
  - wop=10, wa=15 -> all registers unchanged and wz=1.
- Reset mid-operation: five consecutive inc edges on R0 with reset=1 at the 3rd edge -> R0=RESET_VAL+2 after the 5th edge (two increments after reset).
